mem_dispatcher__line_scheduler: RTL and testbench

Sequences full-frame reads from external memory one line at a time by driving the start/address interface of the mem_dispatcher__read unit. It ping-pongs each line into one of two line-buffer banks and hands each filled bank to the downstream pixel consumer. It holds off issuing a line until a bank is free and the read unit is idle.

---
 rtl/mem_dispatcher_pkg.sv | 27 ++
 rtl/mem_dispatcher__bank_tracker.sv | 29 ++
 rtl/mem_dispatcher__line_scheduler.sv | 123 ++++++++++++
 tb/tb_mem_dispatcher__line_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dispatcher_pkg.sv
// Shared definitions for the memory dispatcher blocks: scheduler state encoding,
// read command code, default line pitch and a width helper.
package mem_dispatcher_pkg;

    localparam int DEFAULT_LINE_BYTES = 2560;   // 640 words x 4 B

    localparam logic [1:0] READ_CMD = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RES  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } sched_state_t;

    function automatic int ceil_log2(input int value);
        int bits;
        bits = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) bits = b + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mem_dispatcher__bank_tracker.sv
// Free map of the two line-buffer banks. A release beats an allocate of the
// same bank in the same cycle; releasing a free bank leaves it free.
module mem_dispatcher__bank_tracker
    import mem_dispatcher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc,
    input  logic       alloc_bank,
    input  logic       rel_valid,
    input  logic       rel_bank,
    output logic [1:0] bank_free
);

    logic [1:0] alloc_mask;
    logic [1:0] rel_mask;

    assign alloc_mask = alloc     ? (2'b01 << alloc_bank) : 2'b00;
    assign rel_mask   = rel_valid ? (2'b01 << rel_bank)   : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_free <= 2'b11;
        end else begin
            bank_free <= (bank_free & ~alloc_mask) | rel_mask;
        end
    end

endmodule

// File: rtl/mem_dispatcher__line_scheduler.sv
// Issues one read-unit start per frame line, ping-ponging lines between two
// line-buffer banks and handing each completed bank to the pixel consumer.
module mem_dispatcher__line_scheduler
    import mem_dispatcher_pkg::*;
#(
    parameter int LINES_PER_FRAME = 480,
    parameter int LINE_BYTES      = DEFAULT_LINE_BYTES,
    parameter int LINE_CNT_BITS   = 10,
    parameter int ACK_TIMEOUT     = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [29:0]              frame_base_addr,
    input  logic                     busy_read_unit,
    output logic                     os_start,
    output logic [29:0]              init_mem_addr,
    output logic                     wr_bank,
    output logic                     line_ready,
    output logic                     line_bank,
    output logic [LINE_CNT_BITS-1:0] line_idx,
    input  logic                     bank_release,
    input  logic                     rel_bank,
    output logic                     frame_busy,
    output logic                     frame_done,
    output logic                     ack_err
);

    localparam int ACK_W = ceil_log2(ACK_TIMEOUT + 1);
    localparam logic [29:0]              LINE_STEP = 30'(LINE_BYTES);
    localparam logic [LINE_CNT_BITS-1:0] LAST_LINE = LINE_CNT_BITS'(LINES_PER_FRAME - 1);
    localparam logic [ACK_W-1:0]         ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

    sched_state_t             state;
    logic [29:0]              addr_acc;
    logic [LINE_CNT_BITS-1:0] line_cnt;
    logic [ACK_W-1:0]         ack_cnt;
    logic [1:0]               bank_free;

    mem_dispatcher__bank_tracker u_bank_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc      (state == ST_ISSUE),
        .alloc_bank (wr_bank),
        .rel_valid  (bank_release),
        .rel_bank   (rel_bank),
        .bank_free  (bank_free)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr_acc      <= '0;
            line_cnt      <= '0;
            ack_cnt       <= '0;
            os_start      <= 1'b0;
            init_mem_addr <= '0;
            wr_bank       <= 1'b0;
            line_ready    <= 1'b0;
            line_bank     <= 1'b0;
            line_idx      <= '0;
            frame_busy    <= 1'b0;
            frame_done    <= 1'b0;
            ack_err       <= 1'b0;
        end else begin
            os_start   <= 1'b0;
            line_ready <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        addr_acc   <= frame_base_addr;
                        line_cnt   <= '0;
                        wr_bank    <= 1'b0;
                        frame_busy <= 1'b1;
                        ack_err    <= 1'b0;
                        state      <= ST_WAIT_RES;
                    end
                end
                // Also absorbs read-unit calibration and a transfer left over from a reset.
                ST_WAIT_RES: begin
                    if (bank_free[wr_bank] && !busy_read_unit) begin
                        os_start      <= 1'b1;
                        init_mem_addr <= addr_acc;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ack_cnt <= '0;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (busy_read_unit) begin
                        state <= ST_WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        ack_err <= 1'b1;
                        state   <= ST_FINISH;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!busy_read_unit) begin
                        line_ready <= 1'b1;
                        line_bank  <= wr_bank;
                        line_idx   <= line_cnt;
                        addr_acc   <= addr_acc + LINE_STEP;
                        wr_bank    <= ~wr_bank;
                        line_cnt   <= line_cnt + 1'b1;
                        state      <= (line_cnt == LAST_LINE) ? ST_FINISH : ST_WAIT_RES;
                    end
                end
                ST_FINISH: begin
                    frame_done <= 1'b1;
                    frame_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dispatcher__line_scheduler.sv
// Bench for the line scheduler: read-unit and consumer models drive the DUT, a
// transaction-level model predicts every output each cycle.
module tb_mem_dispatcher__line_scheduler;

    localparam int N_LINES = 4;
    localparam int LB      = 2560;
    localparam int CB      = 10;
    localparam int TO      = 15;
    localparam int RU_LEN  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [29:0]   frame_base_addr = '0;
    logic          busy_read_unit = 1'b0;
    logic          os_start;
    logic [29:0]   init_mem_addr;
    logic          wr_bank;
    logic          line_ready;
    logic          line_bank;
    logic [CB-1:0] line_idx;
    logic          bank_release = 1'b0;
    logic          rel_bank = 1'b0;
    logic          frame_busy;
    logic          frame_done;
    logic          ack_err;

    mem_dispatcher__line_scheduler #(
        .LINES_PER_FRAME (N_LINES),
        .LINE_BYTES      (LB),
        .LINE_CNT_BITS   (CB),
        .ACK_TIMEOUT     (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .frame_base_addr (frame_base_addr),
        .busy_read_unit  (busy_read_unit),
        .os_start        (os_start),
        .init_mem_addr   (init_mem_addr),
        .wr_bank         (wr_bank),
        .line_ready      (line_ready),
        .line_bank       (line_bank),
        .line_idx        (line_idx),
        .bank_release    (bank_release),
        .rel_bank        (rel_bank),
        .frame_busy      (frame_busy),
        .frame_done      (frame_done),
        .ack_err         (ack_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // environment
    int          cyc = 0;
    int          ru_mode = 0;         // 0: busy for RU_LEN cycles after a start, 1: never answers
    bit          force_busy = 1'b0;
    int          ru_start = -1000;
    bit          cons_auto = 1'b1;    // consumer releases a bank 3 cycles after line_ready
    int          rel_due[$];
    bit          rel_bk[$];
    bit          rel_req = 1'b0;
    bit          rel_req_bank = 1'b0;
    bit          fs_req = 1'b0;
    logic [29:0] fs_base = '0;

    // observations
    logic [29:0] os_addrs[$];
    int          os_cycs[$];
    bit          lr_banks[$];
    int          lr_idxs[$];
    int          lr_cycs[$];
    int          fd_cnt = 0;
    int          fd_cyc = 0;

    // transaction model
    bit          m_active, m_pending, m_acked, m_finish;
    int          m_n, m_issue, m_ack;
    logic [29:0] m_base;
    logic [1:0]  m_free;
    bit          e_os, e_lr, e_fd, e_busy, e_err, e_wrb, e_lbank;
    logic [29:0] e_addr;
    int          e_idx;

    task automatic model_reset();
        m_active = 0; m_pending = 0; m_acked = 0; m_finish = 0;
        m_n = 0; m_issue = 0; m_ack = 0; m_base = '0; m_free = 2'b11;
        e_os = 0; e_lr = 0; e_fd = 0; e_busy = 0; e_err = 0; e_wrb = 0; e_lbank = 0;
        e_addr = '0; e_idx = 0;
    endtask

    // Given this cycle's inputs, predict the outputs of the next cycle.
    task automatic model_update();
        bit nxt_os, nxt_lr, nxt_fd;
        logic [1:0] free_now;
        nxt_os = 0; nxt_lr = 0; nxt_fd = 0;
        free_now = m_free;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (e_os) m_free[e_wrb] = 1'b0;
        if (bank_release) m_free[rel_bank] = 1'b1;
        if (!m_active) begin
            if (frame_start) begin
                m_active = 1; m_n = 0; m_pending = 0; m_acked = 0; m_finish = 0;
                m_base = frame_base_addr; e_busy = 1; e_err = 0; e_wrb = 0;
            end
        end else if (m_finish) begin
            nxt_fd = 1; m_active = 0; m_finish = 0; e_busy = 0;
        end else if (!m_pending) begin
            if (free_now[m_n % 2] && !busy_read_unit) begin
                nxt_os = 1;
                e_addr = m_base + 30'(m_n * LB);
                m_pending = 1; m_acked = 0; m_issue = cyc + 1;
            end
        end else if (!m_acked) begin
            if (cyc > m_issue) begin
                if (busy_read_unit) begin
                    m_acked = 1; m_ack = cyc;
                end else if (cyc - m_issue == TO) begin
                    e_err = 1; m_pending = 0; m_finish = 1;
                end
            end
        end else if (cyc > m_ack && !busy_read_unit) begin
            nxt_lr = 1; e_lbank = bit'(m_n % 2); e_idx = m_n;
            m_n++;
            e_wrb = bit'(m_n % 2);
            m_pending = 0; m_acked = 0;
            if (m_n == N_LINES) m_finish = 1;
        end
        e_os = nxt_os; e_lr = nxt_lr; e_fd = nxt_fd;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check("ctrl", {os_start, line_ready, frame_done, frame_busy, ack_err, wr_bank},
              {e_os, e_lr, e_fd, e_busy, e_err, e_wrb});
        if (e_os) check("init_mem_addr", init_mem_addr, e_addr);
        if (e_lr) check("line_meta", {line_bank, line_idx}, {e_lbank, e_idx[CB-1:0]});
        if (os_start) begin
            os_addrs.push_back(init_mem_addr); os_cycs.push_back(cyc); ru_start = cyc;
        end
        if (line_ready) begin
            lr_banks.push_back(line_bank); lr_idxs.push_back(int'(line_idx)); lr_cycs.push_back(cyc);
            if (cons_auto) begin rel_due.push_back(cyc + 3); rel_bk.push_back(line_bank); end
        end
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        busy_read_unit = force_busy || (ru_mode == 0 && cyc >= ru_start + 1 && cyc <= ru_start + RU_LEN);
        bank_release = 1'b0;
        rel_bank = 1'b0;
        if (rel_req) begin
            bank_release = 1'b1; rel_bank = rel_req_bank; rel_req = 1'b0;
        end else if (rel_due.size() > 0 && rel_due[0] <= cyc) begin
            bank_release = 1'b1; rel_bank = rel_bk[0];
            void'(rel_due.pop_front()); void'(rel_bk.pop_front());
        end
        frame_start = fs_req;
        frame_base_addr = fs_base;
        fs_req = 1'b0;
        model_update();
    endtask

    task automatic clear_obs();
        os_addrs.delete(); os_cycs.delete(); lr_banks.delete(); lr_idxs.delete(); lr_cycs.delete();
        fd_cnt = 0; fd_cyc = 0;
    endtask

    task automatic wait_os(input int n, input int budget, input string name);
        int t = 0;
        while (os_addrs.size() < n && t < budget) begin step(); t++; end
        check(name, os_addrs.size() >= n, 1);
    endtask

    task automatic wait_fd(input int n, input int budget, input string name);
        int t = 0;
        while (fd_cnt < n && t < budget) begin step(); t++; end
        check(name, fd_cnt >= n, 1);
    endtask

    task automatic check_zero_outputs(input string name);
        check(name, {os_start, init_mem_addr, wr_bank, line_ready, line_bank, line_idx,
                     frame_busy, frame_done, ack_err}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c_low, r;
        model_reset();
        repeat (3) step();
        check_zero_outputs("reset_outputs");
        rst_n = 1'b1;

        // Calibration: busy held after reset, frame request at cycle 10, full 4-line frame.
        force_busy = 1'b1;
        clear_obs();
        t0 = cyc;
        while (cyc < t0 + 9) step();
        fs_req = 1'b1; fs_base = 30'h100;
        while (cyc < t0 + 50) step();
        check("no_start_while_busy", os_addrs.size(), 0);
        force_busy = 1'b0;
        step();
        c_low = cyc;
        wait_os(1, 5, "first_start_timeout");
        if (os_addrs.size() >= 1) begin
            check("first_start_cycle", os_cycs[0] - c_low, 1);
            check("first_addr", os_addrs[0], 30'h100);
        end
        wait_fd(1, 300, "frameA_done_timeout");
        if (os_addrs.size() == 4 && lr_banks.size() == 4) begin
            check("A_addr1", os_addrs[1], 30'hB00);
            check("A_addr2", os_addrs[2], 30'h1500);
            check("A_addr3", os_addrs[3], 30'h1F00);
            check("A_banks", {lr_banks[0], lr_banks[1], lr_banks[2], lr_banks[3]}, 4'b0101);
            check("A_idx3", lr_idxs[3], 3);
            check("A_done_lat", fd_cyc - lr_cycs[3], 1);
        end else begin
            check("A_counts", {os_addrs.size(), lr_banks.size()}, {32'd4, 32'd4});
        end

        // Consumer holds both banks: scheduler parks after two lines.
        repeat (5) step();
        clear_obs();
        cons_auto = 1'b0;
        fs_req = 1'b1; fs_base = 30'h200;
        repeat (150) step();
        check("B_two_starts", os_addrs.size(), 2);
        check("B_two_lines", lr_banks.size(), 2);
        check("B_busy_parked", frame_busy, 1'b1);
        rel_req = 1'b1; rel_req_bank = 1'b0;
        r = cyc + 1;
        wait_os(3, 5, "B_third_start_timeout");
        if (os_addrs.size() >= 3) begin
            check("B_third_latency", os_cycs[2] - r, 2);
            check("B_third_addr", os_addrs[2], 30'h1600);
        end
        cons_auto = 1'b1;
        rel_req = 1'b1; rel_req_bank = 1'b1;
        wait_fd(1, 200, "frameB_done_timeout");
        if (os_addrs.size() == 4) check("B_addr3", os_addrs[3], 30'h2000);

        // Read unit never acknowledges: abort with ack_err.
        repeat (5) step();
        clear_obs();
        ru_mode = 1;
        fs_req = 1'b1; fs_base = 30'h400;
        wait_fd(1, 60, "C_abort_timeout");
        check("C_ack_err", ack_err, 1'b1);
        check("C_not_busy", frame_busy, 1'b0);
        check("C_no_lines", lr_banks.size(), 0);
        if (os_addrs.size() == 1) check("C_abort_lat", fd_cyc - os_cycs[0], 17);
        ru_mode = 0;
        rel_req = 1'b1; rel_req_bank = 1'b0;
        step();
        clear_obs();
        fs_req = 1'b1; fs_base = 30'h0;
        step();
        step();
        check("C_err_cleared", ack_err, 1'b0);
        wait_fd(1, 200, "frameC2_done_timeout");

        // Asynchronous reset while line 2 is in flight and the read unit stays busy.
        repeat (5) step();
        clear_obs();
        fs_req = 1'b1; fs_base = 30'h300;
        wait_os(3, 200, "D_line2_timeout");
        repeat (8) step();
        force_busy = 1'b1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("D_async_reset");
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        clear_obs();
        fs_req = 1'b1; fs_base = 30'h4000;
        repeat (30) step();
        check("D_held_by_busy", os_addrs.size(), 0);
        force_busy = 1'b0;
        wait_os(1, 5, "D_restart_timeout");
        if (os_addrs.size() >= 1) check("D_restart_addr", os_addrs[0], 30'h4000);
        wait_fd(1, 200, "frameD_done_timeout");

        // Address wrap and a frame_start ignored mid-frame.
        repeat (5) step();
        clear_obs();
        fs_req = 1'b1; fs_base = 30'h3FFFF600;
        repeat (3) step();
        fs_req = 1'b1; fs_base = 30'h12340;
        wait_fd(1, 250, "frameE_done_timeout");
        repeat (10) step();
        check("E_one_frame", fd_cnt, 1);
        check("E_four_starts", os_addrs.size(), 4);
        if (os_addrs.size() == 4) begin
            check("E_addr0", os_addrs[0], 30'h3FFFF600);
            check("E_addr1_wrap", os_addrs[1], 30'h0);
            check("E_addr3", os_addrs[3], 30'h1400);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
